// File: rtl/raccoon_pkg.sv
// raccoon_pkg: shared definitions for the coefficient datapath.
//   COEF_W        - coefficient lane width (bits)
//   PACK_N        - lanes packed into one combined word
//   split_state_t - state encoding of the split_50 unpacker
package raccoon_pkg;

  localparam int COEF_W = 25;
  localparam int PACK_N = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } split_state_t;

endpackage

// File: rtl/split_50.sv
// split_50: unpacks one N*W-bit word into N consecutive W-bit lanes.
// Inverse of the 25->50 combiner: the packed word goes back into 25-bit
// processing units. Both sides use valid/ready handshakes; a new word is
// accepted in the same cycle the last lane of the current word leaves.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   din[N*W]          - packed input word (lane N-1 in the MSBs)
//   din_valid/ready   - input handshake (ready depends on dout_ready)
//   dout[W]           - current output lane
//   dout_valid/ready  - output handshake
//   dout_last         - current lane is the final lane of its word
//   busy              - a word is held (same as dout_valid)
//
// Build option: define SPLIT_50_LSB_FIRST_EN to emit lane 0 first
// (shift right, dout from the LSBs). Default is MSB lane first.
module split_50
  import raccoon_pkg::*;
#(
  parameter int W = COEF_W,
  parameter int N = PACK_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           dout_last,
  output logic           busy
);

  localparam int             IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  split_state_t   state_q;
  logic [IW-1:0]  idx_q;
  logic [N*W-1:0] sreg_q;
  logic [N*W-1:0] sreg_shf;
  logic           at_last;
  logic           accept;
  logic           consume;

`ifdef SPLIT_50_LSB_FIRST_EN
  assign dout     = sreg_q[W-1:0];
  assign sreg_shf = sreg_q >> W;
`else
  assign dout     = sreg_q[N*W-1 -: W];
  assign sreg_shf = sreg_q << W;
`endif

  assign at_last    = (idx_q == LAST_IDX);
  assign dout_valid = (state_q == EMIT);
  assign busy       = dout_valid;
  assign dout_last  = at_last && dout_valid;
  // Only combinational input->output path: the last lane leaving frees
  // the register for the next word in the same cycle.
  assign din_ready  = (state_q == IDLE) || (at_last && dout_ready);

  assign accept  = din_valid && din_ready;
  assign consume = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sreg_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_q  <= din;
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (consume) begin
            if (!at_last) begin
              sreg_q <= sreg_shf;
              idx_q  <= idx_q + 1'b1;
            end else if (accept) begin
              // last lane out, next word in: no bubble
              sreg_q <= din;
              idx_q  <= '0;
            end else begin
              idx_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_50.sv
// tb_split_50: self-checking bench for split_50 (default W=25, N=2).
// Expected lanes are pushed to a scoreboard queue when a word is accepted
// and popped when the DUT hands a lane downstream.
module tb_split_50;

  localparam int W = 25;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] din = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready = 1'b0;
  logic           dout_last;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb[$];   // {last, lane}
  logic [W:0] e;
  logic       acc;

  split_50 #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, settle, and on acceptance push the
  // expected lane order of the word into the scoreboard.
  task automatic step(input logic rdy, input logic vld, input logic [N*W-1:0] d);
    @(negedge clk);
    dout_ready = rdy;
    din_valid  = vld;
    din        = d;
    #1;
    acc = vld && din_ready;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
`ifdef SPLIT_50_LSB_FIRST_EN
        sb.push_back({(i == N-1), d[i*W +: W]});
`else
        sb.push_back({(i == N-1), d[(N-1-i)*W +: W]});
`endif
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, '0);
    step(0, 0, '0);
    checks++;
    if ({dout_valid, dout_last, busy, din_ready} !== 4'b0001 || dout !== '0) begin
      errors++;
      $display("FAIL reset: v/l/b/r=%b%b%b%b dout=%h, want 0001 dout=0",
               dout_valid, dout_last, busy, din_ready, dout);
    end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_single();
    step(1, 1, {25'h1ABCDEF, 25'h0123456});
    step(1, 0, '0);
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency: dout_valid=%b want 1", dout_valid);
    end
    for (int c = 0; c < 2; c++) begin
      if (c == 1) step(1, 0, '0);
      if (dout_valid && dout_ready) begin
        e = sb.pop_front();
        checks++;
        if ({dout_last, dout} !== e) begin
          errors++; $display("FAIL single_lane%0d: got %h want %h", c, {dout_last, dout}, e);
        end
      end
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready_last: din_ready=%b want 1", din_ready);
    end
    step(1, 0, '0);
    checks++;
    if (dout_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL single_end: dout_valid=%b sb=%0d want 0/0", dout_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] w[3];
    int sent = 0, got = 0;
    bit started = 0;
    w[0] = {25'h0000001, 25'h1000002};
    w[1] = {25'h1555555, 25'h0AAAAAA};
    w[2] = {25'h1FFFFFF, 25'h0000000};
    for (int c = 0; c < 40 && got < 6; c++) begin
      step(1, sent < 3, w[sent % 3]);
      if (acc) sent++;
      if (started && !dout_valid) begin
        checks++; errors++;
        $display("FAIL b2b_gap: dout_valid=0 after %0d lanes, want 1", got);
      end
      if (dout_valid) begin
        started = 1;
        checks++;
        if (din_ready !== dout_last) begin
          errors++; $display("FAIL b2b_ready: din_ready=%b want %b", din_ready, dout_last);
        end
        e = sb.pop_front();
        checks++;
        if ({dout_last, dout} !== e) begin
          errors++; $display("FAIL b2b_lane%0d: got %h want %h", got, {dout_last, dout}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL b2b_count: lanes=%0d want 6", got);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold;
    logic         hold_last;
    logic [N*W-1:0] wa = {25'h0F0F0F0, 25'h10F0F0F};
    logic [N*W-1:0] wb = {25'h0123ABC, 25'h1DEF987};
    step(1, 1, wa);
    step(0, 0, '0);
    hold = dout; hold_last = dout_last;
    for (int c = 0; c < 5; c++) begin
      step(0, 1, wb);
      checks++;
      if (dout !== hold || dout_last !== hold_last || din_ready !== 1'b0 || !dout_valid) begin
        errors++;
        $display("FAIL bp_hold%0d: dout=%h last=%b rdy=%b, want %h %b 0",
                 c, dout, dout_last, din_ready, hold, hold_last);
      end
    end
    step(1, 0, '0);
    e = sb.pop_front();
    checks++;
    if ({dout_last, dout} !== e) begin
      errors++; $display("FAIL bp_lane0: got %h want %h", {dout_last, dout}, e);
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 1, wb);
      checks++;
      if (din_ready !== 1'b0 || dout_last !== 1'b1 || acc) begin
        errors++; $display("FAIL bp_last%0d: din_ready=%b last=%b, want 0 1", c, din_ready, dout_last);
      end
    end
    step(1, 1, wb);
    checks++;
    if (!acc) begin
      errors++; $display("FAIL bp_accept: din_ready=%b want 1", din_ready);
    end
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (c > 0) step(1, 0, '0);
      if (dout_valid && dout_ready) begin
        e = sb.pop_front();
        checks++;
        if ({dout_last, dout} !== e) begin
          errors++; $display("FAIL bp_drain: got %h want %h", {dout_last, dout}, e);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL bp_timeout: %0d lanes missing", sb.size());
    end
    step(1, 0, '0);
  endtask

  task automatic test_reset_mid();
    step(1, 1, {25'h1234567, 25'h0765432});
    step(1, 0, '0);
    e = sb.pop_front();
    checks++;
    if ({dout_last, dout} !== e || !dout_valid) begin
      errors++; $display("FAIL rmid_lane0: got %h want %h", {dout_last, dout}, e);
    end
    rst = 1'b1;
    step(1, 0, '0);
    step(1, 0, '0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== '0 || din_ready !== 1'b1 || dout_last !== 1'b0) begin
      errors++; $display("FAIL rmid_state: v=%b dout=%h rdy=%b want 0 0 1", dout_valid, dout, din_ready);
    end
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      step(1, 0, '0);
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_ghost: dout_valid=%b dout=%h want 0", dout_valid, dout);
      end
    end
  endtask

  // Pairs are packed like the upstream combiner: first coefficient in the MSBs.
  task automatic test_round_trip();
    int sent = 0, got = 0, c = 0;
    logic [W-1:0] a, b;
    logic [31:0] r;
    logic [N*W-1:0] cur;
    r = $urandom; a = r[W-1:0];
    r = $urandom; b = r[W-1:0];
    cur = {a, b};
    while ((sent < 1000 || sb.size() > 0) && c < 10000) begin
      step($urandom_range(0, 3) != 0, (sent < 1000) && ($urandom_range(0, 3) != 0), cur);
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL rt_extra: unexpected lane %h", dout);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({dout_last, dout} !== e) begin
            errors++; $display("FAIL rt_lane%0d: got %h want %h", got, {dout_last, dout}, e);
          end
          got++;
        end
      end
      if (acc) begin
        sent++;
        r = $urandom; a = r[W-1:0];
        r = $urandom; b = r[W-1:0];
        cur = {a, b};
      end
      c++;
    end
    checks++;
    if (sent != 1000 || got != 2000) begin
      errors++; $display("FAIL rt_count: sent=%0d lanes=%0d want 1000 2000", sent, got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/split_50.md
# split_50

Unpacker that takes one N·W-bit word (default 50 bits) over a valid/ready handshake and emits it as N consecutive W-bit lanes (default 2 × 25 bits), MSB lane first. It is the inverse of the 25→50 combiner in the coefficient datapath: the combiner's packed word re-enters 25-bit processing units through this block. Input and output are fully back-pressured, and the next word is accepted in the same cycle the last lane of the current word is consumed.

## Interface
- `W`, 25: output lane width in bits.
- `N`, 2: lanes per input word; N ≥ 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  N·W: packed input word; lane N-1 in bits [N·W-1 -: W], lane 0 in bits [W-1:0].
- `din_valid`  in  1: `din` is valid this cycle.
- `din_ready`  out  1: block accepts `din` this cycle.
- `dout`  out  W: current output lane.
- `dout_valid`  out  1: `dout` is valid.
- `dout_ready`  in  1: downstream consumes `dout` this cycle.
- `dout_last`  out  1: the current lane is the final lane of its word.
- `busy`  out  1: a word is held; equals `dout_valid`.

## Operation
- State machine:
  - **IDLE**: no word held. `dout_valid`=0, `din_ready`=1.
  - **EMIT**: word held in shift register `sreg` (N·W bits); lane counter `idx` runs 0..N-1.
- Accept: a word is taken when `din_valid && din_ready`. It loads into `sreg`, sets `idx`=0, and moves the state to EMIT.
- Output: `dout` = top W bits of `sreg`. `dout_last` = (`idx` == N-1) && `dout_valid`.
- Consume: on `dout_valid && dout_ready` with `idx` < N-1, `sreg` shifts left by W and `idx` increments.
- Last lane consumed (`idx`==N-1):
  - if a new word is accepted in the same cycle, it loads and the state stays EMIT with `idx`=0;
  - otherwise the state returns to IDLE.
- `din_ready` = IDLE || (`idx`==N-1 && `dout_ready`). This is a combinational path from `dout_ready`. No other input-to-output combinational path exists.
- `dout_valid` low with `dout_ready` high: no effect. `din_valid` low while ready: no effect.
- Lanes are never dropped or duplicated. Output holds stable while `dout_valid && !dout_ready`.
- Reset mid-word discards the held word. Nothing is emitted for it after reset.

## Timing
- Reset values: state=IDLE, `idx`=0, `sreg`=0, `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `din_ready`=1 (from the first cycle after `rst` is sampled high).
- Latency: a word accepted at edge t gives lane N-1 on `dout` with `dout_valid`=1 in cycle t+1.
- Throughput: one word per N cycles under continuous `dout_ready`=1. There are no bubbles between words.
- A backpressured last lane holds `din_ready`=0 until `dout_ready` rises.

## Configuration
- `SPLIT_50_LSB_FIRST_EN`:
  - **Defined**: lanes are emitted LSB-first (lane 0 first). `sreg` shifts right and `dout` = bits [W-1:0]. `din_ready`, `dout_last`, latency and throughput are unchanged.
  - **Undefined (default)**: lanes are emitted MSB-first, which is the exact inverse of the combiner's packing order.

## Structure
- Shared package `raccoon_pkg`:
  - `COEF_W` (=25) and `PACK_N` (=2), used as the defaults for `W` and `N`;
  - state enum `split_state_t` {IDLE, EMIT}.
- Lane counter width: `$clog2(N)`, minimum 1.
- Single module. No sub-module is needed; the shift register and counter live inline.

## Test plan
- **Single word, free-running sink.** Stimulus: after reset, `din`={25'h1ABCDEF,25'h0123456} with `dout_ready`=1. Required response: `dout`=25'h1ABCDEF (last=0) at t+1, then 25'h0123456 (last=1) at t+2, then `dout_valid`=0.
- **Back-to-back words.** Stimulus: `din_valid` held high for 3 words, `dout_ready`=1. Required response: 6 consecutive valid lanes with no gap; `din_ready` high exactly on each last-lane cycle.
- **Backpressure.** Stimulus: `dout_ready`=0 for 5 cycles mid-word. Required response: `dout` and `dout_last` are stable, `din_ready`=0, and the lane sequence is intact afterwards.
- **Reset mid-word.** Stimulus: `rst` asserted after the first lane. Required response: next cycle `dout_valid`=0, `dout`=0, `din_ready`=1; the second lane is never emitted.
- **Round trip.** Stimulus: 1000 random pairs through the combiner and then `split_50`, with random `dout_ready`. Required response: the output sequence equals the input sequence.
- **`SPLIT_50_LSB_FIRST_EN` defined.** Stimulus: same word as the single-word scenario. Required response: 25'h0123456 first, then 25'h1ABCDEF with last=1.
